// File: rtl/grn_pkg.sv
// Shared FSM state type, default sizing constants and the counter-width check
// for the GRN cycle controller.
package grn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_PERIOD = 3'd3,
        ST_DONE   = 3'd4
    } grn_state_e;

    localparam int GRN_CNT_W     = 16;
    localparam int GRN_MAX_STEPS = 1000;

    // True when a cnt_w-bit unsigned counter can hold max_val.
    function automatic bit cnt_fits(input int cnt_w, input int max_val);
        return (longint'(max_val) < (longint'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/grn_sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; clr has priority over inc.
module grn_sat_counter #(
    parameter int CNT_W = 16,
    parameter int MAX   = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] r_cnt;

    assign cnt    = r_cnt;
    assign at_max = (r_cnt == MAX_C);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && !at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/grn_cycle_ctrl.sv
// Loads an initial state into the GRN node array, steps the nodes Floyd-style
// (s1 hare, s0 tortoise) and reports the attractor meeting step and period.
module grn_cycle_ctrl
    import grn_pkg::*;
#(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = GRN_CNT_W,
    parameter int MAX_STEPS = GRN_MAX_STEPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    output logic               busy,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state_o,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [CNT_W-1:0]   meet_step,
    output logic [CNT_W-1:0]   period,
    output logic               timeout,
    output grn_state_e         o_dbg_state
);

    if (MAX_STEPS < 1 || !cnt_fits(CNT_W, MAX_STEPS)) begin : g_width_check
        $error("grn_cycle_ctrl: CNT_W cannot hold MAX_STEPS");
    end

    grn_state_e         r_state;
    grn_state_e         w_next;
    logic [N_NODES-1:0] r_init;
    logic [CNT_W-1:0]   r_meet;
    logic [CNT_W-1:0]   r_period;
    logic               r_timeout;

    logic [CNT_W-1:0]   w_step;
    logic [CNT_W-1:0]   w_p;
    logic               w_step_max;
    logic               w_p_max;
    logic               w_step_clr;
    logic               w_p_clr;
    logic               w_step_inc;
    logic               w_p_inc;
    logic               w_vec_eq;
    logic               w_hit;
    logic               w_per_eq;
    logic               w_s0;
    logic               w_s1;

    assign w_vec_eq = (s0_vec == s1_vec);
    // Only even step counts compare tortoise t against hare 2t.
    assign w_hit    = (w_step != '0) && !w_step[0] && w_vec_eq;
    assign w_per_eq = (w_p != '0) && w_vec_eq;

    assign w_step_clr = (r_state != ST_RUN);
    assign w_p_clr    = (r_state != ST_PERIOD);
    assign w_step_inc = (r_state == ST_RUN) && w_s0;
    assign w_p_inc    = (r_state == ST_PERIOD) && w_s1;

    grn_sat_counter #(.CNT_W(CNT_W), .MAX(MAX_STEPS)) u_step_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_step_clr),
        .inc    (w_step_inc),
        .cnt    (w_step),
        .at_max (w_step_max)
    );

    grn_sat_counter #(.CNT_W(CNT_W), .MAX(MAX_STEPS)) u_p_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_p_clr),
        .inc    (w_p_inc),
        .cnt    (w_p),
        .at_max (w_p_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_s0   = 1'b0;
        w_s1   = 1'b0;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_LOAD;
            ST_LOAD:   w_next = ST_RUN;
            ST_RUN: begin
                w_s0 = !w_hit;
                w_s1 = !w_hit;
                if (w_hit)           w_next = ST_PERIOD;
                else if (w_step_max) w_next = ST_DONE;
            end
            ST_PERIOD: begin
                w_s1 = !w_per_eq;
                if (w_per_eq || w_p_max) w_next = ST_DONE;
            end
            ST_DONE:   if (result_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init    <= '0;
            r_meet    <= '0;
            r_period  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_init <= init_vec;
            end
            if (r_state == ST_LOAD) begin
                r_meet    <= '0;
                r_period  <= '0;
                r_timeout <= 1'b0;
            end
            if (r_state == ST_RUN) begin
                if (w_hit) begin
                    r_meet <= w_step >> 1;
                end else if (w_step_max) begin
                    r_timeout <= 1'b1;
                end
            end
            if (r_state == ST_PERIOD) begin
                if (w_per_eq) begin
                    r_period <= w_p;
                end else if (w_p_max) begin
                    r_timeout <= 1'b1;
                    r_meet    <= '0;
                end
            end
        end
    end

    // Result port: valid for the whole of DONE, fields frozen there; the
    // transfer happens on the edge where result_ready is high.
    assign busy         = (r_state != ST_IDLE);
    assign reset_nos    = (r_state == ST_LOAD);
    assign init_state_o = r_init;
    assign start_s0     = w_s0 && !rst;
    assign start_s1     = w_s1 && !rst;
    assign result_valid = (r_state == ST_DONE);
    assign meet_step    = r_meet;
    assign period       = r_period;
    assign timeout      = r_timeout;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_grn_cycle_ctrl.sv
// Bench for grn_cycle_ctrl: three controllers (3-node/64, 3-node/4, 8-node/1000)
// drive behavioural node arrays; results are predicted from the state sequence.
module tb_grn_cycle_ctrl;
    import grn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  init_v = 8'h00;
    logic [2:0]  d_start = 3'b000;
    logic [2:0]  d_rdy = 3'b000;
    logic [2:0]  d_busy, d_rnos, d_s0, d_s1, d_valid, d_to;
    logic [15:0] d_meet [3];
    logic [15:0] d_period [3];
    grn_state_e  d_state [3];
    logic [2:0]  io_a, io_b;
    logic [7:0]  io_c;

    logic [7:0]  n_s0 [3] = '{default: 8'h00};
    logic [7:0]  n_s1 [3] = '{default: 8'h00};
    logic [2:0]  n_pass = 3'b000;
    int          net_sel = 0;
    logic [7:0]  rnd_tab [256];

    int cap_meet [3];
    int cap_period [3];
    int cap_to [3];
    int cap_c0 [3];
    int cap_c1 [3];
    int cap_per [3];

    grn_cycle_ctrl #(.N_NODES(3), .MAX_STEPS(64)) u_dut_a (
        .clk(clk), .rst(rst), .start(d_start[0]), .init_vec(init_v[2:0]),
        .busy(d_busy[0]), .reset_nos(d_rnos[0]), .init_state_o(io_a),
        .start_s0(d_s0[0]), .start_s1(d_s1[0]),
        .s0_vec(n_s0[0][2:0]), .s1_vec(n_s1[0][2:0]),
        .result_valid(d_valid[0]), .result_ready(d_rdy[0]),
        .meet_step(d_meet[0]), .period(d_period[0]), .timeout(d_to[0]),
        .o_dbg_state(d_state[0])
    );

    grn_cycle_ctrl #(.N_NODES(3), .MAX_STEPS(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(d_start[1]), .init_vec(init_v[2:0]),
        .busy(d_busy[1]), .reset_nos(d_rnos[1]), .init_state_o(io_b),
        .start_s0(d_s0[1]), .start_s1(d_s1[1]),
        .s0_vec(n_s0[1][2:0]), .s1_vec(n_s1[1][2:0]),
        .result_valid(d_valid[1]), .result_ready(d_rdy[1]),
        .meet_step(d_meet[1]), .period(d_period[1]), .timeout(d_to[1]),
        .o_dbg_state(d_state[1])
    );

    grn_cycle_ctrl #(.N_NODES(8)) u_dut_c (
        .clk(clk), .rst(rst), .start(d_start[2]), .init_vec(init_v),
        .busy(d_busy[2]), .reset_nos(d_rnos[2]), .init_state_o(io_c),
        .start_s0(d_s0[2]), .start_s1(d_s1[2]),
        .s0_vec(n_s0[2]), .s1_vec(n_s1[2]),
        .result_valid(d_valid[2]), .result_ready(d_rdy[2]),
        .meet_step(d_meet[2]), .period(d_period[2]), .timeout(d_to[2]),
        .o_dbg_state(d_state[2])
    );

    function automatic int nw(int i);
        return (i == 2) ? 8 : 3;
    endfunction

    function automatic int mx(int i);
        return (i == 0) ? 64 : ((i == 1) ? 4 : 1000);
    endfunction

    function automatic logic [7:0] init_of(int i);
        case (i)
            0:       return {5'b0, io_a};
            1:       return {5'b0, io_b};
            default: return io_c;
        endcase
    endfunction

    // Network update functions: 0 identity, 1 rotate-left ring, 2 increment, 3 lookup table.
    function automatic logic [7:0] net_f(int sel, logic [7:0] v, int n);
        logic [7:0] m;
        logic [7:0] r;
        m = 8'((1 << n) - 1);
        case (sel)
            0:       r = v;
            1:       r = 8'((v << 1) | (v >> (n - 1)));
            2:       r = 8'(v + 8'd1);
            default: r = rnd_tab[v & m];
        endcase
        return r & m;
    endfunction

    function automatic string tg(string s, int i);
        return $sformatf("%s_%0d", s, i);
    endfunction

    // Node arrays: s1 steps on every strobe, s0 on every second strobe after load.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (d_rnos[i]) begin
                n_s0[i]   <= init_of(i);
                n_s1[i]   <= init_of(i);
                n_pass[i] <= 1'b1;
            end else begin
                if (d_s1[i]) n_s1[i] <= net_f(net_sel, n_s1[i], nw(i));
                if (d_s0[i]) begin
                    if (!n_pass[i]) n_s0[i] <= net_f(net_sel, n_s0[i], nw(i));
                    n_pass[i] <= ~n_pass[i];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk the state sequence to find tail mu and cycle length lam.
    // Floyd meets at the first t>=1 that is a multiple of lam and >=mu.
    task automatic ref_run(input logic [7:0] init, input int n, input int max,
                           output int e_meet, output int e_period, output int e_to,
                           output int e_c0, output int e_c1, output int e_lat,
                           output int e_per);
        int seen [256];
        logic [7:0] x;
        int k, mu, lam, t, lo;
        foreach (seen[j]) seen[j] = -1;
        x = init & 8'((1 << n) - 1);
        k = 0;
        while (seen[x] < 0) begin
            seen[x] = k;
            x = net_f(net_sel, x, n);
            k++;
        end
        mu  = seen[x];
        lam = k - mu;
        lo  = (mu > 1) ? mu : 1;
        t   = lam * ((lo + lam - 1) / lam);
        if (2 * t > max) begin
            e_meet = 0; e_period = 0; e_to = 1;
            e_c0 = max + 1; e_c1 = max + 1; e_lat = max + 3; e_per = 0;
        end else begin
            e_meet = t; e_period = lam; e_to = 0;
            e_c0 = 2 * t; e_c1 = 2 * t + lam; e_lat = 2 * t + lam + 4; e_per = 1;
        end
    endtask

    task automatic run_case(input logic [7:0] init, input int hold, input bit poke);
        int e_meet [3], e_period [3], e_to [3], e_c0 [3], e_c1 [3], e_lat [3], e_per [3];
        int c0 [3], c1 [3], held [3];
        bit per [3], fin [3];
        int cyc;
        for (int i = 0; i < 3; i++) begin
            ref_run(init, nw(i), mx(i), e_meet[i], e_period[i], e_to[i],
                    e_c0[i], e_c1[i], e_lat[i], e_per[i]);
            c0[i] = 0; c1[i] = 0; held[i] = 0; per[i] = 0; fin[i] = 0;
        end
        @(negedge clk);
        init_v  = init;
        d_start = 3'b111;
        cyc = 0;
        while (!(fin[0] && fin[1] && fin[2]) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            d_start = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (fin[i]) continue;
                if (d_rdy[i]) begin
                    d_rdy[i] = 1'b0;
                    check(tg("valid_drop", i), d_valid[i], 0);
                    check(tg("busy_drop", i), d_busy[i], 0);
                    fin[i] = 1'b1;
                end else if (d_valid[i]) begin
                    if (held[i] == 0) begin
                        check(tg("latency", i), cyc, e_lat[i]);
                        check(tg("s0_count", i), c0[i], e_c0[i]);
                        check(tg("s1_count", i), c1[i], e_c1[i]);
                        check(tg("saw_period", i), per[i], e_per[i]);
                        cap_meet[i] = d_meet[i]; cap_period[i] = d_period[i];
                        cap_to[i] = d_to[i]; cap_c0[i] = c0[i]; cap_c1[i] = c1[i];
                        cap_per[i] = per[i];
                    end
                    check(tg("meet", i), d_meet[i], e_meet[i]);
                    check(tg("period", i), d_period[i], e_period[i]);
                    check(tg("timeout", i), d_to[i], e_to[i]);
                    check(tg("done_strobes", i), {d_rnos[i], d_s0[i], d_s1[i]}, 0);
                    if (poke && held[i] == 2) d_start[i] = 1'b1;
                    if (held[i] >= hold) d_rdy[i] = 1'b1;
                    held[i]++;
                end else begin
                    if (d_s0[i]) c0[i]++;
                    if (d_s1[i]) c1[i]++;
                    if (d_state[i] == ST_PERIOD) per[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!fin[i]) check(tg("run_bound", i), 0, 1);
        end
        d_rdy   = 3'b000;
        d_start = 3'b000;
    endtask

    task automatic mid_run_reset();
        @(negedge clk);
        init_v  = 8'h01;
        net_sel = 1;
        d_start = 3'b111;
        @(negedge clk);
        d_start = 3'b000;
        repeat (4) @(negedge clk);
        check("t6_in_run", d_state[0], ST_RUN);
        rst = 1'b1;
        #1;
        check("t6_strobes_same", {d_s0[0], d_s1[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check(tg("t6_busy", i), d_busy[i], 0);
            check(tg("t6_strobes", i), {d_s0[i], d_s1[i]}, 0);
            check(tg("t6_valid", i), d_valid[i], 0);
        end
    endtask

    initial begin
        foreach (rnd_tab[j]) rnd_tab[j] = 8'($urandom_range(0, 255));
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check(tg("rst_busy", i), d_busy[i], 0);
            check(tg("rst_valid", i), d_valid[i], 0);
            check(tg("rst_outs", i), {d_rnos[i], d_s0[i], d_s1[i], d_to[i]}, 0);
            check(tg("rst_meet", i), d_meet[i], 0);
            check(tg("rst_period", i), d_period[i], 0);
            check(tg("rst_init_o", i), init_of(i), 0);
            check(tg("rst_state", i), d_state[i], ST_IDLE);
        end
        rst = 1'b0;

        net_sel = 0;
        run_case(8'h05, 0, 1'b0);
        check("t1_meet", cap_meet[0], 1);
        check("t1_period", cap_period[0], 1);
        check("t1_timeout", cap_to[0], 0);

        net_sel = 1;
        run_case(8'h01, 1, 1'b0);
        check("t2_meet", cap_meet[0], 3);
        check("t2_period", cap_period[0], 3);
        check("t2_s0_cycles", cap_c0[0], 6);
        check("t2_s1_cycles", cap_c1[0], 9);
        check("t4_timeout", cap_to[1], 1);
        check("t4_meet", cap_meet[1], 0);
        check("t4_period", cap_period[1], 0);
        check("t4_no_period", cap_per[1], 0);

        net_sel = 2;
        run_case(8'h00, 0, 1'b0);
        check("t3_meet", cap_meet[0], 8);
        check("t3_period", cap_period[0], 8);
        check("t3_timeout", cap_to[0], 0);

        net_sel = 1;
        run_case(8'h01, 5, 1'b1);
        net_sel = 0;
        run_case(8'h02, 0, 1'b0);
        check("t5_next_meet", cap_meet[0], 1);

        mid_run_reset();
        run_case(8'h01, 0, 1'b0);
        check("t6_meet", cap_meet[0], 3);
        check("t6_period", cap_period[0], 3);
        check("t6_s1_cycles", cap_c1[0], 9);

        repeat (24) begin
            net_sel = int'($urandom_range(0, 3));
            if (net_sel == 3) foreach (rnd_tab[j]) rnd_tab[j] = 8'($urandom_range(0, 255));
            run_case(8'($urandom_range(0, 255)), int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
